// File: rtl/kw_sram_pkg.sv
// kw_sram_pkg
//   Shared types and helpers for the SRAM port controller slice.
//   - ctrl_state_e : controller sequencing states (BOOT -> INIT -> RUN)
//   - wrapInc      : circular pointer increment for non power-of-two depths
package kw_sram_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } ctrl_state_e;

  // Pointer increment that wraps at an arbitrary depth rather than at 2**N.
  function automatic int unsigned wrapInc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/kw_rsp_fifo.sv
// kw_rsp_fifo
//   Small synchronous circular FIFO holding read responses until the
//   consumer takes them. The head entry is presented directly from the
//   storage registers, so the output is registered with no bypass path.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   i_push/i_wdata : write one entry at the tail
//   i_pop          : drop the head entry (caller guarantees non-empty)
//   o_rdata        : head entry
//   o_count        : number of valid entries
module kw_rsp_fifo
  import kw_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         i_push,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  input  logic                         i_pop,
  output logic [DATA_WIDTH-1:0]        o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wrPtr;
  logic [PW-1:0]         r_rdPtr;
  logic [CW-1:0]         r_count;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_wdata;
        r_wrPtr        <= PW'(wrapInc(32'(r_wrPtr), DEPTH));
      end
      if (i_pop) begin
        r_rdPtr <= PW'(wrapInc(32'(r_rdPtr), DEPTH));
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rdPtr];
  assign o_count = r_count;

  // The controller's credit rule must never let the buffer overflow.
  a_noOverflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(i_push && !i_pop && (r_count == CW'(DEPTH))));

  a_noUnderflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(i_pop && (r_count == '0)));

endmodule

// File: rtl/kw_sram_port_ctrl.sv
// kw_sram_port_ctrl
//   Initiator-side controller for a single-port synchronous SRAM. Zero-fills
//   the array after reset (and on init_start), then forwards valid/ready
//   requests to the SRAM and returns read data through a response FIFO.
// Ports:
//   clock, reset_n          : clock and asynchronous active-low reset
//   init_start / init_busy  : re-run zero-fill / sweep in progress
//   req_*                   : request channel (write, addr, wdata)
//   rsp_*                   : read-response channel with backpressure
//   sram_*                  : SRAM strobes (active low), address, data
module kw_sram_port_ctrl
  import kw_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int RSP_DEPTH  = 3,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  init_start,
  output logic                  init_busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_cs_n,
  output logic                  sram_we_n,
  output logic                  sram_re_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  ctrl_state_e           r_state;
  ctrl_state_e           w_nextState;
  logic [ADDR_WIDTH-1:0] r_sweepCnt;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_lastAddr;
  logic [DATA_WIDTH-1:0] r_lastWdata;

  req_t                  w_req;
  logic                  w_fire;
  logic                  w_pop;
  logic [CW-1:0]         w_count;
  logic [CW:0]           w_credit;
  logic                  w_sweepLast;
  logic                  w_csN;
  logic                  w_weN;
  logic                  w_reN;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_req = '{write: req_write, addr: req_addr, wdata: req_wdata};

  // Credits count both buffered and in-flight reads so a read that is
  // already on its way always has a free slot waiting for it.
  assign w_credit    = {1'b0, w_count} + (CW+1)'(r_inflight);
  assign req_ready   = (r_state == RUN) && !init_start && (w_credit < (CW+1)'(RSP_DEPTH));
  assign w_fire      = req_valid && req_ready;
  assign w_sweepLast = (r_sweepCnt == ADDR_WIDTH'(DEPTH - 1));
  assign init_busy   = (r_state != RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= BOOT;
      r_sweepCnt  <= '0;
      r_inflight  <= 1'b0;
      r_lastAddr  <= '0;
      r_lastWdata <= '0;
    end else begin
      r_state     <= w_nextState;
      r_sweepCnt  <= (r_state == INIT && !w_sweepLast) ? r_sweepCnt + 1'b1 : '0;
      r_inflight  <= w_fire && !w_req.write;
      // Idle cycles keep presenting whatever was last driven.
      r_lastAddr  <= w_addr;
      r_lastWdata <= w_wdata;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_csN       = 1'b1;
    w_weN       = 1'b1;
    w_reN       = 1'b1;
    w_addr      = r_lastAddr;
    w_wdata     = r_lastWdata;
    case (r_state)
      BOOT: begin
        w_nextState = INIT;
        w_addr      = '0;
        w_wdata     = '0;
      end
      INIT: begin
        w_csN   = 1'b0;
        w_weN   = 1'b0;
        w_addr  = r_sweepCnt;
        w_wdata = '0;
        if (w_sweepLast) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (init_start) begin
          w_nextState = BOOT;
        end
        if (w_fire) begin
          w_csN   = 1'b0;
          w_weN   = !w_req.write;
          w_reN   = w_req.write;
          w_addr  = w_req.addr;
          w_wdata = w_req.wdata;
        end
      end
      default: begin
        w_nextState = BOOT;
      end
    endcase
  end

  assign sram_cs_n  = w_csN;
  assign sram_we_n  = w_weN;
  assign sram_re_n  = w_reN;
  assign sram_addr  = w_addr;
  assign sram_wdata = w_wdata;

  // SRAM data for a read issued last cycle is captured while r_inflight is
  // set; this is independent of state so a re-init does not lose it.
  assign rsp_valid = (w_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;

  kw_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rspFifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (r_inflight),
    .i_wdata (sram_rdata),
    .i_pop   (w_pop),
    .o_rdata (rsp_rdata),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_kw_sram_port_ctrl.sv
// tb_kw_sram_port_ctrl
//   Drives kw_sram_port_ctrl against a behavioural single-port SRAM. A
//   reference memory predicts read data; predictions are queued on each
//   accepted read and compared as responses are consumed.
module tb_kw_sram_port_ctrl;

  localparam int DW  = 32;
  localparam int DEP = 64;
  localparam int RD  = 3;
  localparam int AW  = $clog2(DEP);

  logic          clock      = 1'b0;
  logic          reset_n    = 1'b1;
  logic          init_start = 1'b0;
  logic          req_valid  = 1'b0;
  logic          req_write  = 1'b0;
  logic [AW-1:0] req_addr   = '0;
  logic [DW-1:0] req_wdata  = '0;
  logic          rsp_ready  = 1'b1;
  logic          init_busy;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          sram_cs_n;
  logic          sram_we_n;
  logic          sram_re_n;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  logic [DW-1:0] sramMem [DEP];
  logic [DW-1:0] refMem  [DEP];
  logic [DW-1:0] expQ [$];

  int nCompared   = 0;
  int nMismatched = 0;
  int cycleCnt    = 0;
  int rspSeen     = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt++;

  kw_sram_port_ctrl #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEP),
    .RSP_DEPTH  (RD)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .init_start (init_start),
    .init_busy  (init_busy),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .sram_cs_n  (sram_cs_n),
    .sram_we_n  (sram_we_n),
    .sram_re_n  (sram_re_n),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Single-port synchronous SRAM: read data appears after the read edge.
  always @(posedge clock) begin
    if (!sram_cs_n) begin
      if (!sram_we_n) sramMem[sram_addr] <= sram_wdata;
      else if (!sram_re_n) sram_rdata <= sramMem[sram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard: predict on request fire, compare on response handshake,
  // and confirm the response holds steady while stalled.
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData  = '0;
  always @(negedge clock) begin
    if (!reset_n) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stallValid", 64'(rsp_valid), 64'd1);
        checkOutput("stallData", 64'(rsp_rdata), 64'(prevData));
      end
      prevStall = rsp_valid && !rsp_ready;
      prevData  = rsp_rdata;
      if (req_valid && req_ready) begin
        if (req_write) refMem[req_addr] = req_wdata;
        else expQ.push_back(refMem[req_addr]);
      end
      if (rsp_valid && rsp_ready) begin
        rspSeen++;
        if (expQ.size() == 0) checkOutput("rspUnexpected", 64'(expQ.size()), 64'd1);
        else checkOutput("rspData", 64'(rsp_rdata), 64'(expQ.pop_front()));
      end
    end
  end

  task automatic clearRef();
    for (int i = 0; i < DEP; i++) refMem[i] = '0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Ctl"},
                64'({init_busy, req_ready, rsp_valid, sram_cs_n, sram_we_n, sram_re_n, sram_addr}),
                64'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, {AW{1'b0}}}));
    checkOutput({tag, "Data"}, {rsp_rdata, sram_wdata}, 64'd0);
  endtask

  // Present one request and hold it until accepted; returns 1ns after the
  // accepting edge with req_valid still asserted.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int waitCnt = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(negedge clock);
    while (!req_ready && waitCnt < 200) begin
      waitCnt++;
      @(negedge clock);
    end
    if (!req_ready) checkOutput("reqTimeout", 64'(req_ready), 64'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic waitDrain(input string tag);
    int c = 0;
    while ((expQ.size() != 0 || rsp_valid) && c < 100) begin
      @(negedge clock);
      c++;
    end
    checkOutput(tag, 64'(expQ.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int startCycle;
    int startRsp;
    int acc;
    int busyCycles;
    int sweepWrites;
    int staleCnt;

    for (int i = 0; i < DEP; i++) sramMem[i] = 32'hA5A5_0000 | 32'(i);
    clearRef();

    // Reset values and the boot/zero-fill sequence.
    #1 reset_n = 1'b0;
    #2 checkResetValues("reset");
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    checkOutput("bootStrobes", 64'({init_busy, req_ready, sram_cs_n, sram_we_n, sram_re_n}), 64'b10111);
    for (int i = 0; i < DEP; i++) begin
      @(negedge clock);
      checkOutput("sweep", 64'({sram_cs_n, sram_we_n, sram_re_n, sram_addr, sram_wdata}),
                  64'({3'b001, AW'(i), 32'h0}));
    end
    @(negedge clock);
    checkOutput("runBusy", 64'(init_busy), 64'd0);
    checkOutput("runReady", 64'(req_ready), 64'd1);
    @(posedge clock);
    #1;

    // Distinct contents for ordering checks.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, AW'(i), 32'h1000_0000 + 32'(i) * 32'h0101);
    req_valid = 1'b0;

    // Write then read on the next cycle; read latency of two cycles.
    applyStimulus(1'b1, AW'(5), 32'hDEAD_BEEF);
    applyStimulus(1'b0, AW'(5), '0);
    req_valid = 1'b0;
    @(negedge clock);
    checkOutput("latT1", 64'(rsp_valid), 64'd0);
    @(negedge clock);
    checkOutput("latT2", 64'(rsp_valid), 64'd1);
    checkOutput("rdHit", 64'(rsp_rdata), 64'hDEAD_BEEF);
    @(posedge clock);
    #1;
    applyStimulus(1'b0, AW'(6 + 20), '0);
    req_valid = 1'b0;
    waitDrain("drainA");

    // Back-to-back reads with the consumer always ready.
    startCycle = cycleCnt;
    startRsp   = rspSeen;
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, AW'(i), '0);
    req_valid = 1'b0;
    checkOutput("b2bCycles", 64'(cycleCnt - startCycle), 64'd16);
    waitDrain("drainB");
    checkOutput("b2bCount", 64'(rspSeen - startRsp), 64'd16);

    // Backpressure: only RSP_DEPTH reads fit, acceptance resumes after a pop.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = AW'(10);
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (req_ready) acc++;
      @(posedge clock);
      #1;
      req_addr = AW'(10 + acc);
    end
    checkOutput("stallAccepts", 64'(acc), 64'd3);
    @(negedge clock);
    checkOutput("stallReady", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1 rsp_ready = 1'b1;
    @(negedge clock);
    checkOutput("resumeHold", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("resumeReady", 64'(req_ready), 64'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    waitDrain("drainC");

    // Re-init with a read in flight.
    startRsp = rspSeen;
    applyStimulus(1'b0, AW'(9), '0);
    req_valid  = 1'b0;
    init_start = 1'b1;
    @(negedge clock);
    checkOutput("initBlocks", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1 init_start = 1'b0;
    clearRef();
    busyCycles  = 0;
    sweepWrites = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (!init_busy) break;
      busyCycles++;
      if (!sram_cs_n && !sram_we_n && sram_wdata == '0) sweepWrites++;
    end
    checkOutput("reinitBusy", 64'(busyCycles), 64'd65);
    checkOutput("reinitWrites", 64'(sweepWrites), 64'd64);
    checkOutput("reinitRsp", 64'(rspSeen - startRsp), 64'd1);
    @(posedge clock);
    #1;
    applyStimulus(1'b0, AW'(9), '0);
    req_valid = 1'b0;
    waitDrain("drainD");

    // Asynchronous reset with two responses buffered.
    rsp_ready = 1'b0;
    applyStimulus(1'b0, AW'(3), '0);
    applyStimulus(1'b0, AW'(4), '0);
    req_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("preResetValid", 64'(rsp_valid), 64'd1);
    @(posedge clock);
    #3 reset_n = 1'b0;
    expQ.delete();
    clearRef();
    #1 checkResetValues("midReset");
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    rsp_ready = 1'b1;
    staleCnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      if (rsp_valid) staleCnt++;
    end
    checkOutput("noStale", 64'(staleCnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/kw_sram_port_ctrl.md
Name: kw_sram_port_ctrl

Overview:
- Initiator-side controller for the team's single-port synchronous SRAM wrapper. It drives the SRAM's active-low chip-select, write-enable and output-enable, its address and its write data, and captures the read data.
- Upstream sees a valid/ready request channel and a valid/ready read-response channel with backpressure.
- After reset, and on request, it zero-fills the whole array.
- Sits between a compute/buffer unit and one SRAM macro instance.

Parameters:
- DATA_WIDTH, 32, word width; must equal the SRAM's DATA_WIDTH.
- DEPTH, 64, number of words; must equal the SRAM's DEPTH; need not be a power of 2.
- RSP_DEPTH, 3, response buffer entries; minimum 2; 3 gives one read per cycle with rsp_ready held high.
- ADDR_WIDTH, $clog2(DEPTH), derived; do not override.

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- init_start  in  1  pulse: re-run the zero-fill sweep
- init_busy  out  1  high while in BOOT or INIT
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer ready
- rsp_rdata  out  DATA_WIDTH  read data
- sram_cs_n  out  1  SRAM chip select, active low
- sram_we_n  out  1  SRAM write enable, active low
- sram_re_n  out  1  SRAM output enable, active low
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data; valid the cycle after the read edge

Behaviour:
- States are BOOT, INIT and RUN. Reset puts the block in BOOT with sweep counter = 0, in-flight flag = 0, buffer empty.
- BOOT:
  - Lasts exactly 1 cycle, then goes to INIT.
  - All SRAM strobes deasserted (cs_n = we_n = re_n = 1), addr = 0, wdata = 0.
- INIT:
  - Each cycle: cs_n = 0, we_n = 0, re_n = 1, addr = counter, wdata = 0.
  - Counter increments each cycle. When counter == DEPTH-1, the next state is RUN and the counter clears.
  - Sweep is exactly DEPTH cycles.
  - req_ready = 0; init_start is ignored.
- RUN:
  - SRAM signals are combinational from the request on a fire cycle: cs_n = 0, we_n = !req_write, re_n = req_write, addr = req_addr, wdata = req_wdata.
  - On a non-fire cycle: cs_n = we_n = re_n = 1; addr and wdata hold the last driven value.
  - init_start high in RUN: next state BOOT (which proceeds to INIT); no request is accepted that cycle.
- req_ready = (state == RUN) && !init_start && (buf_count + inflight < RSP_DEPTH). It is registered-state derived with no path from rsp_ready; it does not depend on req_write.
- Writes produce no response. Write-to-read ordering is inherent: a write at cycle t is visible to a read issued at t+1.
- Read latency:
  - Read accepted at cycle t: inflight = 1 during t+1.
  - sram_rdata is pushed into the buffer at the end of t+1.
  - rsp_valid rises at t+2 (2-cycle latency, registered output, no bypass).
- Response buffer:
  - RSP_DEPTH-entry circular FIFO with rd/wr pointers that wrap modulo RSP_DEPTH, plus a count.
  - Push and pop in the same cycle leave the count unchanged.
  - The credit rule guarantees overflow is impossible; an assertion checks it.
  - rsp_rdata = head entry. rsp_rdata and rsp_valid stay stable while rsp_valid && !rsp_ready.
- Re-init with a read in flight: the pending read still captures at t+1 into the buffer. The buffer is not flushed by BOOT/INIT, so buffered responses drain normally during the sweep.
- Reset values: init_busy = 1, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, sram_cs_n = sram_we_n = sram_re_n = 1, sram_addr = 0, sram_wdata = 0.
- Asynchronous reset mid-operation discards in-flight reads and buffered data; the sweep restarts from BOOT.

Decomposition:
- kw_sram_pkg holds:
  - the state enum (BOOT, INIT, RUN);
  - the request struct {write, addr, wdata}, parameterised via a typedef in the module.
- One sub-module, kw_rsp_fifo: parameterised DATA_WIDTH × RSP_DEPTH synchronous FIFO with count output, on the same clock/reset.
- The bench instantiates the controller against the existing SRAM wrapper at DEPTH = 64, DATA_WIDTH = 32.

Test Plan:
- Reset release -> BOOT 1 cycle, then 64 cycles of cs_n = 0 / we_n = 0 at addr 0..63, wdata 0; init_busy falls at cycle 65; req_ready high at cycle 65.
- Write 0xDEADBEEF @5, then read @5 on the next cycle -> rsp_valid 2 cycles after the read fire, rsp_rdata = 0xDEADBEEF; unwritten read @6 returns 0.
- 16 back-to-back reads with rsp_ready = 1 -> req_ready never drops; 16 responses in address order, one per cycle.
- Reads with rsp_ready = 0 -> exactly 3 reads accepted, then req_ready = 0. Releasing rsp_ready drains the 3 in order with data stable while stalled; accepts resume the cycle after the first pop.
- init_start pulsed the cycle after a read @9 fires -> read data is delivered; sweep of 64 writes follows; a later read @9 returns 0.
- reset_n asserted mid-stream with 2 buffered responses -> all outputs at reset values immediately; no stale rsp_valid after release.
